// File: rtl/stage_decode.sv
// rtl/stage_decode.sv - RV32I decode stage: IF/ID register, register file, decoder, load-use hazard detection
module stage_decode #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     in_PC,
  input  logic [31:0]     in_instruction,
  input  logic            branch_taken,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            out_valid,
  output logic [31:0]     out_PC,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0]     if_pc;
  logic [31:0]     if_instr;
  logic            if_valid;
  logic [XLEN-1:0] rf [0:31];

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_used;
  logic            rs2_used;
  logic            legal;
  logic            load_use;

  // Flush wins over stall; a flushed slot keeps its PC but becomes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pc    <= '0;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (branch_taken) begin
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (!stall) begin
      if_pc    <= in_PC;
      if_instr <= in_instruction;
      if_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_reg_write && (wb_rd != 5'd0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  assign opcode = if_instr[6:0];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  // Same-cycle writeback is forwarded so ID never sees a stale operand.
  always_comb begin
    out_rs1_data = '0;
    if (rs1 != 5'd0) begin
      if (wb_reg_write && (wb_rd == rs1)) out_rs1_data = wb_data;
      else                                out_rs1_data = rf[rs1];
    end
  end

  always_comb begin
    out_rs2_data = '0;
    if (rs2 != 5'd0) begin
      if (wb_reg_write && (wb_rd == rs2)) out_rs2_data = wb_data;
      else                                out_rs2_data = rf[rs2];
    end
  end

  always_comb begin
    out_imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR:
        out_imm = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE:
        out_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH:
        out_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                   if_instr[30:25], if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        out_imm = {if_instr[31:12], 12'b0};
      OP_JAL:
        out_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                   if_instr[20], if_instr[30:21], 1'b0};
      default:
        out_imm = '0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
      OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase
  end

  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL:  rs1_used = 1'b0;
      OP_REG, OP_STORE, OP_BRANCH: rs2_used = 1'b1;
      default: begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
      end
    endcase
  end

  // The load in EX moves on next cycle, so a load-use stall is one cycle long.
  assign load_use = if_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));

  assign stall       = load_use && !branch_taken;
  assign out_valid   = if_valid && !stall && !branch_taken;
  assign out_illegal = if_valid && !legal;

  assign out_PC     = if_pc;
  assign out_rs1    = rs1;
  assign out_rs2    = rs2;
  assign out_rd     = if_instr[11:7];
  assign out_opcode = opcode;
  assign out_funct3 = if_instr[14:12];
  assign out_funct7 = if_instr[31:25];

endmodule

// File: tb/tb_stage_decode.sv
// tb/tb_stage_decode.sv - directed and randomized check of stage_decode against a reference model
module tb_stage_decode;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_PC, in_instruction;
  logic        branch_taken, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, out_valid;
  logic [31:0] out_PC, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_illegal;

  stage_decode #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .in_PC(in_PC), .in_instruction(in_instruction),
    .branch_taken(branch_taken), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .out_valid(out_valid), .out_PC(out_PC),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_stall;
  logic [31:0] m_rf [32];
  logic [6:0]  legal_ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                  7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Immediates rebuilt as integers: gather the field value, then fold into signed range.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin
        v = int'(ins >> 20);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = int'(ins >> 25) * 32 + int'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h6F: begin
        v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
      default:      v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic br,
                       input logic emr, input logic [4:0] exrd, input logic wen,
                       input logic [4:0] wrd, input logic [31:0] wd);
    in_PC = pc; in_instruction = ins; branch_taken = br; ex_mem_read = emr;
    ex_rd = exrd; wb_reg_write = wen; wb_rd = wrd; wb_data = wd;
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_valid = 1'b0; m_stall = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  // Compare every output against the model for this cycle, then advance the model.
  task automatic step();
    logic [6:0] op;
    logic [4:0] r1, r2;
    logic       u1, u2;
    #1;
    op = m_instr[6:0];
    r1 = m_instr[19:15];
    r2 = m_instr[24:20];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    m_stall = m_valid && ex_mem_read && ex_rd != 5'd0 && !branch_taken &&
              ((u1 && ex_rd == r1) || (u2 && ex_rd == r2));
    chk("stall", 32'(stall), 32'(m_stall));
    chk("valid", 32'(out_valid), 32'(m_valid && !m_stall && !branch_taken));
    chk("pc", out_PC, m_pc);
    chk("imm", out_imm, ref_imm(m_instr));
    chk("rs1", 32'(out_rs1), 32'(r1));
    chk("rs2", 32'(out_rs2), 32'(r2));
    chk("rd", 32'(out_rd), 32'(m_instr[11:7]));
    chk("opcode", 32'(out_opcode), 32'(op));
    chk("funct3", 32'(out_funct3), 32'(m_instr[14:12]));
    chk("funct7", 32'(out_funct7), 32'(m_instr[31:25]));
    chk("rs1_data", out_rs1_data, ref_read(r1));
    chk("rs2_data", out_rs2_data, ref_read(r2));
    chk("illegal", 32'(out_illegal), 32'(m_valid && !is_legal(op)));
    if (wb_reg_write && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
    if (branch_taken) begin
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (!m_stall) begin
      m_pc = in_PC;
      m_instr = in_instruction;
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins;
    int          sel;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", out_PC, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_rs1_data", out_rs1_data, 0);
    chk("rst_illegal", 32'(out_illegal), 0);
    reset = 1'b0;

    drive(32'h0, 32'h0050_0093, 0, 0, 0, 0, 0, 0); step();
    drive(32'h4, 32'h0031_8233, 0, 0, 0, 0, 0, 0); #1;
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_pc", out_PC, 0);
    chk("addi_rd", 32'(out_rd), 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_rs1_data", out_rs1_data, 0);
    step();
    drive(32'h8, 32'h0031_8233, 0, 0, 0, 1, 3, 32'hDEAD_BEEF); #1;
    chk("bypass_rs1", out_rs1_data, 32'hDEAD_BEEF);
    chk("bypass_rs2", out_rs2_data, 32'hDEAD_BEEF);
    step();
    drive(32'hC, 32'h0050_0093, 0, 0, 0, 1, 0, 32'h1234); #1;
    chk("persist_rs1", out_rs1_data, 32'hDEAD_BEEF);
    step();
    drive(32'h10, 32'h0072_8333, 0, 0, 0, 1, 0, 32'h1234); #1;
    chk("x0_read", out_rs1_data, 0);
    step();
    drive(32'h14, 32'h0010_0113, 0, 1, 5, 0, 0, 0); #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_valid", 32'(out_valid), 0);
    step();
    drive(32'h14, 32'h0072_8333, 0, 0, 0, 0, 0, 0); #1;
    chk("lu_hold_pc", out_PC, 32'h10);
    chk("lu_hold_rd", 32'(out_rd), 6);
    chk("lu_release_stall", 32'(stall), 0);
    chk("lu_release_valid", 32'(out_valid), 1);
    step();
    drive(32'h18, 32'h0000_2023, 1, 1, 5, 0, 0, 0); #1;
    chk("flush_stall", 32'(stall), 0);
    chk("flush_valid", 32'(out_valid), 0);
    step();
    drive(32'h100, 32'hFE11_2E23, 0, 0, 0, 0, 0, 0); #1;
    chk("flush_bubble_valid", 32'(out_valid), 0);
    chk("flush_bubble_op", 32'(out_opcode), 32'h13);
    chk("flush_bubble_pc", out_PC, 32'h14);
    step();
    drive(32'h104, 32'hFE00_0EE3, 0, 0, 0, 0, 0, 0); #1;
    chk("imm_sw", out_imm, 32'hFFFF_FFFC);
    step();
    drive(32'h108, 32'h0080_006F, 0, 0, 0, 0, 0, 0); #1;
    chk("imm_beq", out_imm, 32'hFFFF_FFFC);
    step();
    drive(32'h10C, 32'h1234_50B7, 0, 0, 0, 0, 0, 0); #1;
    chk("imm_jal", out_imm, 32'h8);
    step();
    drive(32'h110, 32'h0000_007F, 0, 0, 0, 0, 0, 0); #1;
    chk("imm_lui", out_imm, 32'h1234_5000);
    step();
    drive(32'h114, NOP, 0, 0, 0, 0, 0, 0); #1;
    chk("illegal_7f", 32'(out_illegal), 1);
    step();

    for (int t = 0; t < 400; t++) begin
      sel = int'($urandom_range(0, 13));
      ins = $urandom;
      ins[6:0]   = (sel < 11) ? legal_ops[sel] : 7'($urandom);
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      ins[11:7]  = 5'($urandom_range(0, 7));
      drive($urandom & 32'hFFFF_FFFC, ins, ($urandom_range(0, 9) == 0),
            m_stall ? 1'b0 : ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      step();
    end

    drive(32'h200, 32'h0031_8233, 0, 0, 0, 1, 3, 32'hCAFE_0001); step();
    drive(32'h204, 32'h0031_8233, 0, 0, 0, 0, 0, 0); step();
    #1;
    chk("pre_rst_rs1", out_rs1_data, 32'hCAFE_0001);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_pc", out_PC, 0);
    chk("async_rst_op", 32'(out_opcode), 32'h13);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(32'h300, 32'h0031_8233, 0, 0, 0, 0, 0, 0); step();
    drive(32'h304, NOP, 0, 0, 0, 0, 0, 0); #1;
    chk("post_rst_x3", out_rs1_data, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
